// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard, forwarding, flush and memory-wait controller
module pipe_hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int JMP_FLUSH   = 2,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_wreg,
    input  logic             ex_rmem,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wreg,
    input  logic             mem_rmem,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             wb_wreg,
    input  logic             ex_jmp,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             hold_pc,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             freeze,
    output logic [1:0]       fwd1,
    output logic [1:0]       fwd2,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        FLUSH    = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(JMP_FLUSH - 1);
    localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);

    state_t     cur;
    logic [2:0] flush_cnt;
    logic [7:0] wait_cnt;

    logic m_ex1, m_ex2, m_mem1, m_mem2, m_wb1, m_wb2;
    logic load_use, mem_stall, wait_done;

    assign m_ex1  = id_use1 && ex_wreg  && (ex_dest  == id_src1);
    assign m_ex2  = id_use2 && ex_wreg  && (ex_dest  == id_src2);
    assign m_mem1 = id_use1 && mem_wreg && (mem_dest == id_src1);
    assign m_mem2 = id_use2 && mem_wreg && (mem_dest == id_src2);
    assign m_wb1  = id_use1 && wb_wreg  && (wb_dest  == id_src1);
    assign m_wb2  = id_use2 && wb_wreg  && (wb_dest  == id_src2);

    // A load's data only exists after MEM, so a load match can never be forwarded from EX or EX/MEM.
    assign load_use  = (m_ex1 && ex_rmem) || (m_mem1 && mem_rmem) ||
                       (m_ex2 && ex_rmem) || (m_mem2 && mem_rmem);
    assign mem_stall = mem_req && !mem_ready;
    assign wait_done = mem_ready || (wait_cnt == TIMEOUT);
    assign state     = cur;

    function automatic logic [1:0] fwd_sel(input logic mex, input logic mmem, input logic mwb);
        if (mex && !ex_rmem)
            return 2'b01;
        else if (mmem && !mem_rmem)
            return 2'b10;
        else if (mwb)
            return 2'b11;
        else
            return 2'b00;
    endfunction

    always_comb begin
        hold_pc   = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        freeze    = 1'b0;
        fwd1      = 2'b00;
        fwd2      = 2'b00;
        if (!rst) begin
            fwd1 = fwd_sel(m_ex1, m_mem1, m_wb1);
            fwd2 = fwd_sel(m_ex2, m_mem2, m_wb2);
            case (cur)
                MEM_WAIT: freeze = !wait_done;
                FLUSH: begin
                    if (mem_stall)
                        freeze = 1'b1;
                    else
                        flush_id = 1'b1;
                end
                default: begin
                    if (mem_stall) begin
                        freeze = 1'b1;
                    end else if (ex_jmp) begin
                        flush_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (load_use) begin
                        hold_pc   = 1'b1;
                        bubble_ex = 1'b1;
                    end
                end
            endcase
        end
    end

    // A flush cycle interrupted by a memory stall is not consumed; flush_cnt survives MEM_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= RUN;
            flush_cnt <= 3'd0;
            wait_cnt  <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if ((hold_pc || freeze) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            case (cur)
                MEM_WAIT: begin
                    if (wait_done) begin
                        if (!mem_ready)
                            mem_err <= 1'b1;
                        wait_cnt <= 8'd0;
                        cur      <= (flush_cnt != 3'd0) ? FLUSH : RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                FLUSH: begin
                    if (mem_stall) begin
                        cur      <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                        if (flush_cnt == 3'd1)
                            cur <= RUN;
                    end
                end
                default: begin
                    if (mem_stall) begin
                        cur      <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end else if (ex_jmp && (JMP_FLUSH > 1)) begin
                        cur       <= FLUSH;
                        flush_cnt <= FLUSH_INIT;
                    end else begin
                        cur <= RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with a behavioural reference model
module tb_pipe_hazard_ctrl;

    localparam int REG_W   = 4;
    localparam int JF      = 2;
    localparam int TO      = 4;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        bit rst;
        int src1, src2;
        bit use1, use2;
        int ex_dest;  bit ex_wreg;  bit ex_rmem;
        int mem_dest; bit mem_wreg; bit mem_rmem;
        int wb_dest;  bit wb_wreg;
        bit jmp, req, rdy;
    } stim_t;

    typedef struct {
        int hold, bub, fl, frz, f1, f2, err, scnt, st;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [REG_W-1:0] id_src1, id_src2, ex_dest, mem_dest, wb_dest;
    logic id_use1, id_use2, ex_wreg, ex_rmem, mem_wreg, mem_rmem, wb_wreg;
    logic ex_jmp, mem_req, mem_ready;
    logic hold_pc, bubble_ex, flush_id, freeze, mem_err;
    logic [1:0] fwd1, fwd2, state;
    logic [CNT_W-1:0] stall_cnt;

    pipe_hazard_ctrl #(.REG_W(REG_W), .JMP_FLUSH(JF), .MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_dest(ex_dest), .ex_wreg(ex_wreg), .ex_rmem(ex_rmem),
        .mem_dest(mem_dest), .mem_wreg(mem_wreg), .mem_rmem(mem_rmem),
        .wb_dest(wb_dest), .wb_wreg(wb_wreg),
        .ex_jmp(ex_jmp), .mem_req(mem_req), .mem_ready(mem_ready),
        .hold_pc(hold_pc), .bubble_ex(bubble_ex), .flush_id(flush_id), .freeze(freeze),
        .fwd1(fwd1), .fwd2(fwd2), .mem_err(mem_err), .stall_cnt(stall_cnt), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    // Reference model: mode 0 = running, 1 = squashing, 2 = waiting on memory.
    int m_mode = 0, m_flush_left = 0, m_waited = 0, m_err = 0, m_stalls = 0;

    function automatic int ref_fwd(input stim_t s, input int src, input bit u);
        int  dest[3];
        bit  wr[3];
        bit  no_fwd[3];
        dest = '{s.ex_dest, s.mem_dest, s.wb_dest};
        wr   = '{s.ex_wreg, s.mem_wreg, s.wb_wreg};
        no_fwd = '{s.ex_rmem, s.mem_rmem, 1'b0};
        if (!u) return 0;
        for (int k = 0; k < 3; k++)
            if (wr[k] && dest[k] == src && !no_fwd[k]) return k + 1;
        return 0;
    endfunction

    function automatic bit ref_load_use(input stim_t s, input int src, input bit u);
        return u && ((s.ex_wreg && s.ex_dest == src && s.ex_rmem) ||
                     (s.mem_wreg && s.mem_dest == src && s.mem_rmem));
    endfunction

    task automatic model(input stim_t s, input bit track);
        exp_t e;
        e = '{default: 0};
        e.err  = m_err;
        e.scnt = m_stalls;
        e.st   = m_mode;
        if (s.rst) begin
            m_mode = 0; m_flush_left = 0; m_waited = 0; m_err = 0; m_stalls = 0;
        end else begin
            e.f1 = ref_fwd(s, s.src1, s.use1);
            e.f2 = ref_fwd(s, s.src2, s.use2);
            if (m_mode == 2) begin
                if (s.rdy || m_waited == TO) begin
                    if (!s.rdy) m_err = 1;
                    m_waited = 0;
                    m_mode = (m_flush_left > 0) ? 1 : 0;
                end else begin
                    e.frz = 1;
                    m_waited++;
                end
            end else if (s.req && !s.rdy) begin
                e.frz = 1;
                m_mode = 2;
                m_waited = 1;
            end else if (m_mode == 1) begin
                e.fl = 1;
                m_flush_left--;
                if (m_flush_left == 0) m_mode = 0;
            end else if (s.jmp) begin
                e.fl = 1; e.bub = 1;
                if (JF > 1) begin m_mode = 1; m_flush_left = JF - 1; end
            end else if (ref_load_use(s, s.src1, s.use1) || ref_load_use(s, s.src2, s.use2)) begin
                e.hold = 1; e.bub = 1;
            end
            if (e.hold || e.frz) m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
        end
        if (track) exp_q.push_back(e);
    endtask

    task automatic step(input stim_t s, input bit track = 1'b1);
        @(posedge clk);
        #1;
        rst = s.rst;
        id_src1 = REG_W'(s.src1); id_src2 = REG_W'(s.src2);
        id_use1 = s.use1; id_use2 = s.use2;
        ex_dest = REG_W'(s.ex_dest); ex_wreg = s.ex_wreg; ex_rmem = s.ex_rmem;
        mem_dest = REG_W'(s.mem_dest); mem_wreg = s.mem_wreg; mem_rmem = s.mem_rmem;
        wb_dest = REG_W'(s.wb_dest); wb_wreg = s.wb_wreg;
        ex_jmp = s.jmp; mem_req = s.req; mem_ready = s.rdy;
        model(s, track);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hold_pc",   int'(hold_pc),   e.hold);
            check("bubble_ex", int'(bubble_ex), e.bub);
            check("flush_id",  int'(flush_id),  e.fl);
            check("freeze",    int'(freeze),    e.frz);
            check("fwd1",      int'(fwd1),      e.f1);
            check("fwd2",      int'(fwd2),      e.f2);
            check("mem_err",   int'(mem_err),   e.err);
            check("stall_cnt", int'(stall_cnt), e.scnt);
            check("state",     int'(state),     e.st);
        end
    end

    initial begin
        stim_t s, idle;
        idle = '{default: 0};
        idle.rdy = 1'b1;
        s = idle; s.rst = 1'b1;
        step(s, 1'b0);
        step(s, 1'b0);
        step(s);
        // forward from EX ALU
        s = idle; s.ex_dest = 3; s.ex_wreg = 1; s.src1 = 3; s.use1 = 1; s.src2 = 7;
        step(s);
        // load-use through EX, MEM, then WB forward
        s = idle; s.ex_dest = 5; s.ex_wreg = 1; s.ex_rmem = 1; s.src2 = 5; s.use2 = 1;
        step(s);
        s = idle; s.mem_dest = 5; s.mem_wreg = 1; s.mem_rmem = 1; s.src2 = 5; s.use2 = 1;
        step(s);
        s = idle; s.wb_dest = 5; s.wb_wreg = 1; s.src2 = 5; s.use2 = 1;
        step(s);
        // jump, ignored jump in squash cycle
        s = idle; s.jmp = 1;
        step(s); step(s);
        step(idle);
        // three-cycle memory wait
        s = idle; s.req = 1; s.rdy = 0;
        step(s); step(s); step(s);
        s.rdy = 1;
        step(s);
        step(idle);
        // memory timeout
        s = idle; s.req = 1; s.rdy = 0;
        for (int i = 0; i < 7; i++) step(s);
        step(idle);
        // jump, stall during squash, resume squash
        s = idle; s.jmp = 1; step(s);
        s = idle; s.req = 1; s.rdy = 0; step(s);
        s.rdy = 1; step(s);
        step(idle); step(idle);
        // reset during a wait interrupted squash
        s = idle; s.jmp = 1; step(s);
        s = idle; s.req = 1; s.rdy = 0; step(s); step(s);
        s.rst = 1; step(s);
        step(idle); step(idle);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s.rst      = ($urandom_range(0, 299) == 0);
            s.src1     = $urandom_range(0, 3);
            s.src2     = $urandom_range(0, 3);
            s.use1     = $urandom_range(0, 1);
            s.use2     = $urandom_range(0, 1);
            s.ex_dest  = $urandom_range(0, 3);
            s.ex_wreg  = $urandom_range(0, 1);
            s.ex_rmem  = ($urandom_range(0, 3) == 0);
            s.mem_dest = $urandom_range(0, 3);
            s.mem_wreg = $urandom_range(0, 1);
            s.mem_rmem = ($urandom_range(0, 3) == 0);
            s.wb_dest  = $urandom_range(0, 3);
            s.wb_wreg  = $urandom_range(0, 1);
            s.jmp      = ($urandom_range(0, 7) == 0);
            s.req      = ($urandom_range(0, 2) == 0);
            s.rdy      = ($urandom_range(0, 2) != 0);
            step(s);
        end
        step(idle, 1'b0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage CPU pipeline: IF, ID, EX, MEM and WB, with the EX/MEM register carrying wmem/rmem/wreg/jmp, the ALU result and the 4-bit destination.
- Detects data hazards against the instruction in ID and generates per-source forwarding selects.
- Inserts load-use bubbles, squashes wrong-path instructions after a taken jump, and freezes the whole pipeline while data memory is busy.
- Sits beside the pipeline registers and drives their hold and flush controls.

Parameters:
- REG_W, 4, register-index width.
- JMP_FLUSH, 2, cycles of squash after a taken jump; range 1..7.
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before an error is flagged; range 1..255.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_src1, id_src2  in  REG_W  source registers of the instruction in ID
- id_use1, id_use2  in  1  the matching source is actually read
- ex_dest  in  REG_W, ex_wreg  in  1, ex_rmem  in  1  instruction in EX
- mem_dest  in  REG_W, mem_wreg  in  1, mem_rmem  in  1  instruction in MEM
- wb_dest  in  REG_W, wb_wreg  in  1  instruction in WB
- ex_jmp  in  1  taken jump resolved in EX
- mem_req  in  1  MEM stage is accessing data memory (wmem|rmem)
- mem_ready  in  1  data-memory acknowledge
- hold_pc  out  1  hold PC and the IF/ID register
- bubble_ex  out  1  load a NOP into ID/EX
- flush_id  out  1  squash the IF/ID register
- freeze  out  1  hold every pipeline register, including EX/MEM and MEM/WB
- fwd1, fwd2  out  2  00 = register file, 01 = EX ALU output, 10 = EX/MEM ALU result, 11 = WB data
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt  out  CNT_W  saturating count of cycles with hold_pc or freeze asserted
- state  out  2  00 RUN, 01 FLUSH, 10 MEM_WAIT

Behaviour:
- Reset is synchronous: state=RUN, flush_cnt=0, wait_cnt=0, mem_err=0, stall_cnt=0.
- While rst is high, every control output (hold_pc, bubble_ex, flush_id, freeze, fwd1, fwd2) is forced to 0.
- All control outputs are combinational from the current state and inputs, so they take effect in the same cycle. State and counters update on posedge clk.
- Match definitions:
  - matchX(s) = useN && Xwreg && Xdest==srcN, for stage X in {ex, mem, wb}.
  - Register 0 is not special.
- Forwarding, per source: fwdN = 01 if matchEX and !ex_rmem; else 10 if matchMEM and !mem_rmem; else 11 if matchWB; else 00. EX has the highest priority.
- Load-use hazard: (matchEX && ex_rmem) or (matchMEM && mem_rmem) on either source.
  - Response: hold_pc=1, bubble_ex=1 for that cycle.
  - Total penalty is 2 cycles when the load is in EX and 1 cycle when it is in MEM.
- Memory wait has top priority in every state.
  - If mem_req && !mem_ready: freeze=1 in that cycle, next state MEM_WAIT, wait_cnt=1.
- RUN:
  - Memory wait, as above.
  - Else if ex_jmp: flush_id=1, bubble_ex=1. If JMP_FLUSH>1, go to FLUSH with flush_cnt=JMP_FLUSH-1.
  - Else handle any load-use hazard.
  - Else no control outputs are asserted.
- FLUSH:
  - flush_id=1; ex_jmp is ignored because it belongs to a squashed instruction.
  - flush_cnt decrements each cycle; return to RUN when it reaches 0.
  - Hazard stalls are not evaluated while in FLUSH.
- MEM_WAIT:
  - freeze=1 every cycle and wait_cnt increments. flush_cnt is preserved.
  - On mem_ready: freeze=0 in that cycle and the pipeline advances. Next state is FLUSH if flush_cnt>0, else RUN.
  - If wait_cnt==MEM_TIMEOUT and !mem_ready: set mem_err=1 and leave exactly as on mem_ready, with freeze=0 in that cycle.
  - mem_err clears only on rst.
- stall_cnt increments on any cycle with hold_pc|freeze and saturates at all-ones.
- Reset asserted mid-FLUSH or mid-MEM_WAIT returns to RUN on the next edge; the pending flush is discarded.

Test Plan:
- EX: ADD r3 (wreg, !rmem), ID: id_src1=3, use1=1 -> fwd1=01, fwd2=00, no stall, stall_cnt unchanged.
- EX: LOAD r5, ID uses r5 as src2 -> hold_pc=1, bubble_ex=1. Next cycle with the load in MEM -> still stalled. Following cycle with the load in WB -> fwd2=11, stall_cnt=2.
- ex_jmp=1 in RUN with JMP_FLUSH=2 -> flush_id=1 and bubble_ex=1 in cycle 0, state=FLUSH with flush_id=1 in cycle 1, RUN in cycle 2. An ex_jmp during cycle 1 is ignored.
- mem_req=1, mem_ready low for 3 cycles -> freeze=1 for 3 cycles and state=MEM_WAIT. Ready on the 4th cycle -> freeze=0, RUN, stall_cnt=3.
- MEM_TIMEOUT=4, mem_ready never asserted -> mem_err=1 after the 4th wait cycle, state back to RUN, mem_err stays 1 until rst.
- ex_jmp then mem stall in the FLUSH cycle, then mem_ready -> state sequence RUN, FLUSH, MEM_WAIT, FLUSH, RUN. Asserting rst during MEM_WAIT -> RUN and all counters 0 on the next edge.
